// File: rtl/hr_bridge_lanes.sv
// hr_bridge_lanes: multi-lane hierarchical-ring bridge with per-lane up/down transfer FIFOs and deflection on full.
// Optional HRB_DEFLECT_STATS_EN adds per-lane saturating deflection counters on defl_cnt.
module hr_bridge_lanes #(
    parameter int LANES     = 4,
    parameter int W         = 144,
    parameter int DEPTH     = 4,
    parameter int VALID_BIT = 0,
    parameter int DST_LSB   = 4,
    parameter int DST_W     = 4,
    parameter int RING_ID   = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [LANES*W-1:0]                    loc_i,
    output logic [LANES*W-1:0]                    loc_o,
    input  logic [LANES*W-1:0]                    glb_i,
    output logic [LANES*W-1:0]                    glb_o,
    output logic [LANES*($clog2(DEPTH)+1)-1:0]    up_cnt,
    output logic [LANES*($clog2(DEPTH)+1)-1:0]    dn_cnt
`ifdef HRB_DEFLECT_STATS_EN
    ,
    output logic [LANES*16-1:0]                   defl_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [DST_W-1:0] RID = DST_W'(RING_ID);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [W-1:0]  up_mem [DEPTH];
        logic [W-1:0]  dn_mem [DEPTH];
        logic [AW-1:0] up_wp, up_rp, dn_wp, dn_rp;
        logic [CW-1:0] up_c, dn_c;
        logic [W-1:0]  li, gi, lo_d, go_d, lo_q, go_q;
        logic          lv, gv, l_rem, g_loc;
        logic          up_push, dn_push, up_pop, dn_pop, l_defl, g_defl;

        assign li = loc_i[k*W +: W];
        assign gi = glb_i[k*W +: W];
        assign lv = li[VALID_BIT];
        assign gv = gi[VALID_BIT];
        assign l_rem = lv && (li[DST_LSB +: DST_W] != RID);
        assign g_loc = gv && (gi[DST_LSB +: DST_W] == RID);

        // Full is judged on the registered count only, so a pop never frees room for a same-cycle push
        assign up_push = l_rem && (up_c != FULL);
        assign dn_push = g_loc && (dn_c != FULL);
        assign l_defl  = l_rem && (up_c == FULL);
        assign g_defl  = g_loc && (dn_c == FULL);
        assign dn_pop  = (!lv || up_push) && (dn_c != '0);
        assign up_pop  = (!gv || dn_push) && (up_c != '0);

        assign lo_d = dn_pop ? dn_mem[dn_rp] : ((lv && !up_push) ? li : '0);
        assign go_d = up_pop ? up_mem[up_rp] : ((gv && !dn_push) ? gi : '0);

        always_ff @(posedge clk) begin
            if (rst) begin
                up_wp <= '0;
                up_rp <= '0;
                dn_wp <= '0;
                dn_rp <= '0;
                up_c  <= '0;
                dn_c  <= '0;
                lo_q  <= '0;
                go_q  <= '0;
            end else begin
                lo_q <= lo_d;
                go_q <= go_d;
                up_c <= up_c + CW'(up_push) - CW'(up_pop);
                dn_c <= dn_c + CW'(dn_push) - CW'(dn_pop);
                if (up_push) begin
                    up_mem[up_wp] <= li;
                    up_wp <= up_wp + AW'(1);
                end
                if (dn_push) begin
                    dn_mem[dn_wp] <= gi;
                    dn_wp <= dn_wp + AW'(1);
                end
                if (up_pop) up_rp <= up_rp + AW'(1);
                if (dn_pop) dn_rp <= dn_rp + AW'(1);
            end
        end

        assign loc_o[k*W +: W]   = lo_q;
        assign glb_o[k*W +: W]   = go_q;
        assign up_cnt[k*CW +: CW] = up_c;
        assign dn_cnt[k*CW +: CW] = dn_c;

`ifdef HRB_DEFLECT_STATS_EN
        logic [15:0] st_q;
        logic [16:0] st_sum;
        assign st_sum = {1'b0, st_q} + 17'(l_defl) + 17'(g_defl);
        always_ff @(posedge clk) begin
            if (rst) st_q <= '0;
            else st_q <= st_sum[16] ? 16'hFFFF : st_sum[15:0];
        end
        assign defl_cnt[k*16 +: 16] = st_q;
`endif
    end
endmodule

// File: tb/tb_hr_bridge_lanes.sv
// tb_hr_bridge_lanes: directed table-driven bench for hr_bridge_lanes with default parameters.
module tb_hr_bridge_lanes;
    localparam int LANES = 4;
    localparam int W = 144;
    localparam int CW = 3;
    localparam int LW = LANES * W;
    localparam int CL = LANES * CW;

    logic clk = 0;
    logic rst;
    logic [LW-1:0] loc_i, glb_i, loc_o, glb_o;
    logic [CL-1:0] up_cnt, dn_cnt;
`ifdef HRB_DEFLECT_STATS_EN
    logic [LANES*16-1:0] defl_cnt;
`endif
    int errs = 0;
    int checks = 0;

    hr_bridge_lanes dut (
        .clk(clk), .rst(rst), .loc_i(loc_i), .loc_o(loc_o), .glb_i(glb_i), .glb_o(glb_o),
        .up_cnt(up_cnt), .dn_cnt(dn_cnt)
`ifdef HRB_DEFLECT_STATS_EN
        , .defl_cnt(defl_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] li, gi, lo, go;
        logic [CL-1:0] uc, dc;
    } vec_t;
    vec_t tv[11];

    function automatic logic [W-1:0] f(logic v, logic [3:0] dst, logic [127:0] tag);
        logic [W-1:0] x;
        x = '0;
        x[W-1:16] = tag;
        x[7:4] = dst;
        x[3:1] = 3'b101;
        x[0] = v;
        return x;
    endfunction

    function automatic logic [LW-1:0] put(int k, logic [W-1:0] x);
        return LW'(x) << (k * W);
    endfunction

    function automatic logic [CL-1:0] cn(int a, int b, int c, int d);
        return {CW'(d), CW'(c), CW'(b), CW'(a)};
    endfunction

    task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        loc_i = '0;
        glb_i = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        step();
        rst = 0;
    endtask

    initial begin
        tv[0]  = '{put(0, f(1, 1, 'hA1)), '0, '0, '0, cn(1, 0, 0, 0), '0};
        tv[1]  = '{'0, '0, '0, put(0, f(1, 1, 'hA1)), '0, '0};
        tv[2]  = '{put(1, f(1, 0, 'hB1)), '0, put(1, f(1, 0, 'hB1)), '0, '0, '0};
        tv[3]  = '{'0, put(2, f(1, 0, 'hC1)), '0, '0, '0, cn(0, 0, 1, 0)};
        tv[4]  = '{'0, '0, put(2, f(1, 0, 'hC1)), '0, '0, '0};
        tv[5]  = '{'0, put(3, f(1, 3, 'hD1)), '0, put(3, f(1, 3, 'hD1)), '0, '0};
        tv[6]  = '{put(0, f(0, 1, 'hEE)), put(1, f(0, 0, 'hEF)), '0, '0, '0, '0};
        tv[7]  = '{put(3, f(1, 2, 'h71)), put(3, f(1, 5, 'h72)), '0, put(3, f(1, 5, 'h72)),
                   cn(0, 0, 0, 1), '0};
        tv[8]  = '{'0, '0, '0, put(3, f(1, 2, 'h71)), '0, '0};
        tv[9]  = '{put(0, f(1, 0, 'h90)) | put(1, f(1, 7, 'h91)),
                   put(2, f(1, 0, 'h92)) | put(3, f(1, 9, 'h93)),
                   put(0, f(1, 0, 'h90)), put(3, f(1, 9, 'h93)), cn(0, 1, 0, 0), cn(0, 0, 1, 0)};
        tv[10] = '{'0, '0, put(2, f(1, 0, 'h92)), put(1, f(1, 7, 'h91)), '0, '0};

        rst = 1;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < LW / 32; i++) begin
                loc_i[i*32 +: 32] = $urandom;
                glb_i[i*32 +: 32] = $urandom;
            end
            step();
            chk($sformatf("rst%0d_loc", c), loc_o, '0);
            chk($sformatf("rst%0d_glb", c), glb_o, '0);
            chk($sformatf("rst%0d_cnt", c), LW'({up_cnt, dn_cnt}), '0);
        end
        rst = 0;

        for (int i = 0; i < 11; i++) begin
            loc_i = tv[i].li;
            glb_i = tv[i].gi;
            step();
            chk($sformatf("vec%0d_loc", i), loc_o, tv[i].lo);
            chk($sformatf("vec%0d_glb", i), glb_o, tv[i].go);
            chk($sformatf("vec%0d_up", i), LW'(up_cnt), LW'(tv[i].uc));
            chk($sformatf("vec%0d_dn", i), LW'(dn_cnt), LW'(tv[i].dc));
        end

        // Up-FIFO fill, deflect on full, and refused push while a pop happens
        do_reset();
        for (int i = 0; i < 5; i++) begin
            loc_i = put(0, f(1, 1, 128'hF0 + 128'(i)));
            glb_i = put(0, f(1, 2, 128'hE0 + 128'(i)));
            step();
            chk($sformatf("full%0d_glb", i), glb_o, put(0, f(1, 2, 128'hE0 + 128'(i))));
            chk($sformatf("full%0d_loc", i), loc_o, (i == 4) ? put(0, f(1, 1, 128'hF4)) : '0);
            chk($sformatf("full%0d_up", i), LW'(up_cnt), LW'(cn((i < 4) ? i + 1 : 4, 0, 0, 0)));
        end
`ifdef HRB_DEFLECT_STATS_EN
        chk("defl_one", LW'(defl_cnt[15:0]), LW'(16'd1));
`endif
        loc_i = put(0, f(1, 1, 'hF5));
        glb_i = '0;
        step();
        chk("nowt_glb", glb_o, put(0, f(1, 1, 'hF0)));
        chk("nowt_loc", loc_o, put(0, f(1, 1, 'hF5)));
        chk("nowt_up", LW'(up_cnt), LW'(cn(3, 0, 0, 0)));
`ifdef HRB_DEFLECT_STATS_EN
        chk("defl_two", LW'(defl_cnt[15:0]), LW'(16'd2));
`endif
        idle();
        for (int j = 1; j < 4; j++) begin
            step();
            chk($sformatf("drain%0d_glb", j), glb_o, put(0, f(1, 1, 128'hF0 + 128'(j))));
            chk($sformatf("drain%0d_up", j), LW'(up_cnt), LW'(cn(3 - j, 0, 0, 0)));
        end

        // Down-FIFO at 3 with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 3; i++) begin
            loc_i = put(1, f(1, 0, 128'h50 + 128'(i)));
            glb_i = put(1, f(1, 0, 128'hC0 + 128'(i)));
            step();
            chk($sformatf("dfill%0d_loc", i), loc_o, put(1, f(1, 0, 128'h50 + 128'(i))));
            chk($sformatf("dfill%0d_dn", i), LW'(dn_cnt), LW'(cn(0, i + 1, 0, 0)));
        end
        loc_i = '0;
        glb_i = put(1, f(1, 0, 'hC3));
        step();
        chk("simul_loc", loc_o, put(1, f(1, 0, 'hC0)));
        chk("simul_glb", glb_o, '0);
        chk("simul_dn", LW'(dn_cnt), LW'(cn(0, 3, 0, 0)));
        idle();
        for (int j = 1; j < 4; j++) begin
            step();
            chk($sformatf("ddrain%0d_loc", j), loc_o, put(1, f(1, 0, 128'hC0 + 128'(j))));
            chk($sformatf("ddrain%0d_dn", j), LW'(dn_cnt), LW'(cn(0, 3 - j, 0, 0)));
        end

        // Mid-stream reset discards buffered flits
        glb_i = put(2, f(1, 0, 'h33));
        loc_i = put(2, f(1, 0, 'h34));
        step();
        step();
        chk("pre_rst_dn", LW'(dn_cnt), LW'(cn(0, 0, 2, 0)));
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_loc", loc_o, '0);
        chk("mid_rst_cnt", LW'({up_cnt, dn_cnt}), '0);
        idle();
        step();
        chk("post_rst_loc", loc_o, '0);
        chk("post_rst_dn", LW'(dn_cnt), '0);

`ifdef HRB_DEFLECT_STATS_EN
        do_reset();
        loc_i = put(0, f(1, 1, 'h11));
        glb_i = put(0, f(1, 2, 'h22));
        for (int i = 0; i < 4; i++) step();
        for (int n = 1; n <= 65537; n++) begin
            step();
            if (n == 65534) chk("sat_fffe", LW'(defl_cnt[15:0]), LW'(16'hFFFE));
            if (n == 65535) chk("sat_ffff", LW'(defl_cnt[15:0]), LW'(16'hFFFF));
        end
        chk("sat_hold", LW'(defl_cnt[15:0]), LW'(16'hFFFF));
        rst = 1;
        step();
        rst = 0;
        chk("sat_rst", LW'(defl_cnt), '0);
        chk("sat_rst_up", LW'(up_cnt), '0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
